fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Output reorder stage placed directly downstream of `fft_sc`. It receives the FFT's bit-reversed-order output stream and buffers each `FFT_SIZE`-sample frame in a ping-pong memory. It then replays each frame in natural bin order (bin 0 first) with frame-start and frame-end markers. Input has no backpressure, matching `fft_sc`; the buffer depth guarantees no loss at full rate.

## Interface
- `FFT_SIZE`, 1024, frame length in samples; power of two, 8..65536
- `DATA_WIDTH`, `fft_pkg::DATA_WIDTH`, width of each real/imag component
- `clk  in  1`  single clock, all logic on rising edge
- `rst_n  in  1`  asynchronous, active-low reset
- `din_re  in  DATA_WIDTH`  real part, bit-reversed order
- `din_im  in  DATA_WIDTH`  imaginary part
- `din_valid  in  1`  sample qualifier; may drop low at any cycle, including mid-frame
- `dout_re  out  DATA_WIDTH`  real part, natural order
- `dout_im  out  DATA_WIDTH`  imaginary part
- `dout_valid  out  1`  output qualifier; high for exactly `FFT_SIZE` consecutive cycles per frame
- `dout_sof  out  1`  high with bin 0
- `dout_eof  out  1`  high with bin `FFT_SIZE-1`
- `ovf  out  1`  sticky overflow flag, cleared only by reset

## Operation
- Memory: two banks of `FFT_SIZE` × `2*DATA_WIDTH`. `wr_bank` selects the bank being filled; `rd_bank` selects the bank being drained.
- Write side: `wr_cnt` (log2 `FFT_SIZE` bits) increments on each `din_valid`. Write address is `bitrev(wr_cnt)`, so input sample k lands at address `bitrev(k)`. The first `din_valid` after reset is sample 0 of a frame.
- When `wr_cnt` wraps (last sample of a frame written):
  - mark the bank full;
  - toggle `wr_bank`;
  - raise a one-cycle `frame_done` pulse to the read side.
- Read side FSM:
  - `IDLE`: waits for `frame_done`, then latches `rd_bank` from the just-filled bank and moves to `READ`.
  - `READ`: `rd_cnt` steps 0..`FFT_SIZE-1`, one address per cycle, natural order. After address `FFT_SIZE-1` it clears the bank's full flag. It then goes to `IDLE`, or starts the next frame back to back if a `frame_done` is pending.
- Pending `frame_done` arriving while in `READ` is held in a 1-deep pending flag and serviced immediately after the current frame.
- Overflow: if a write would enter a bank whose full flag is still set, set `ovf`. The sample is still written (data corrupted, no stall). This cannot occur at ≤1 sample/cycle; the flag is a checker hook.
- `dout_re`/`dout_im` hold their last value when `dout_valid` is low.
- No arithmetic: data passes bit-exact.

## Timing
- Reset values: `dout_re`, `dout_im`, `dout_valid`, `dout_sof`, `dout_eof`, `ovf` all 0. `wr_cnt`, `rd_cnt`, bank selects and full flags are 0; FSM is in `IDLE`.
- Memory read is synchronous, 1 cycle, and outputs are registered.
- Latency: if the last sample of a frame is sampled at edge T, then bin 0 appears with `dout_valid` high after edge T+2.
- `dout_valid` stays high for `FFT_SIZE` cycles with no gaps, regardless of input gaps.
- Continuous input (N samples per N cycles) gives continuous output with no idle cycle between frames.
- Simultaneous write wrap and read completion in the same cycle: completion clears its bank's flag and the new `frame_done` is accepted in the same cycle. Nothing is lost or duplicated.
- Reset mid-frame: any partial input frame and any in-flight output frame are discarded. Outputs drop to 0 asynchronously, and the next `din_valid` is sample 0.
- Mid-frame `din_valid` gaps only delay `frame_done`; they never shift address mapping.

## Structure
- `fft_pkg` additions:
  - `localparam`-derivable `clog2` usage for address width;
  - a `bitrev` function parameterised by width;
  - an `rd_state_t` enum (`IDLE`, `READ`).
- One sub-module, `fft_dp_ram`: simple dual-port RAM with one write port and one synchronous read port, depth `2*FFT_SIZE`, with bank select as the address MSB. It is inferable as block RAM.
- Top holds the write counter, full flags, read FSM and output registers.
- Instantiate in the bench after `fft_sc` (`dout_*` → `din_*`).

## Test plan
- `FFT_SIZE=8`: one frame with din_re=k at input index k for k=0..7 (addresses 0,4,2,6,1,5,3,7) → dout_re sequence 0,4,2,6,1,5,3,7 natural-reordered; equivalently, feeding values bitrev(n) yields 0..7. `sof` is high on the first output, `eof` on the eighth, and bin 0 appears 2 cycles after the last input.
- Three back-to-back frames at full rate → 24 consecutive `dout_valid` cycles, with frames correct and in order, and `ovf` staying 0.
- Input with `din_valid` toggling every other cycle → output frames still gap-free, 8 cycles each, with correct data.
- Assert `rst_n` low at output bin 3 of frame 1 → outputs are 0 immediately. After release, a fresh frame emerges complete from bin 0.
- Force the full flag (or backdoor a second-bank fill during `READ`) → `ovf` goes to 1 and stays 1 until reset.
- `FFT_SIZE=1024` with `fft_sc` upstream on a random vector → bench output equals reference DFT bins in natural order.

Source files
------------

// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared types and helpers for the FFT bit-reversed-to-natural reorder stage.
//   DATA_WIDTH : default width of each real/imaginary component
//   MAX_AW     : widest address the bitrev helper supports (FFT_SIZE up to 65536)
//   rd_state_t : read-side FSM states
//   bitrev()   : reverses the low 'w' bits of a value
package fft_bitrev_reorder_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int MAX_AW     = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // Reverse all MAX_AW bits, then shift down so only the low w bits remain.
    function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] v, input int w);
        logic [MAX_AW-1:0] r;
        r = {MAX_AW{1'b0}};
        for (int i = 0; i < MAX_AW; i++) begin
            r[MAX_AW-1-i] = v[i];
        end
        return r >> (MAX_AW - w);
    endfunction

endpackage

// File: rtl/fft_dp_ram.sv
// Simple dual-port RAM: one write port, one synchronous (1-cycle) read port.
// No reset on the array or read register so it maps onto block RAM.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : registered read data
module fft_dp_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Synchronous read port
    always_ff @(posedge clk) begin
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders an FFT output stream from bit-reversed to natural bin order using a
// ping-pong buffer. Each frame is written at bitrev(index) and replayed with
// a linear read counter, marked with start/end-of-frame flags.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   din_re, din_im, din_valid   : bit-reversed input samples (no backpressure)
//   dout_re, dout_im, dout_valid: natural-order output samples
//   dout_sof, dout_eof          : high with bin 0 / bin FFT_SIZE-1
//   ovf                         : sticky, set when a write enters a still-full bank
module fft_bitrev_reorder #(
    parameter int FFT_SIZE   = 1024,
    parameter int DATA_WIDTH = fft_bitrev_reorder_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_re,
    input  logic [DATA_WIDTH-1:0] din_im,
    input  logic                  din_valid,
    output logic [DATA_WIDTH-1:0] dout_re,
    output logic [DATA_WIDTH-1:0] dout_im,
    output logic                  dout_valid,
    output logic                  dout_sof,
    output logic                  dout_eof,
    output logic                  ovf
);
    import fft_bitrev_reorder_pkg::*;

    localparam int AW = $clog2(FFT_SIZE);
    localparam int DW2 = 2 * DATA_WIDTH;

    // Write side
    logic [AW-1:0]     wr_cnt_r;
    logic              wr_bank_r;
    logic [1:0]        full_r;
    logic              frame_done_s;
    logic [MAX_AW-1:0] wr_rev_s;

    // Read side
    rd_state_t         rd_state_r;
    rd_state_t         rd_state_s;
    logic [AW-1:0]     rd_cnt_r;
    logic              rd_bank_r;
    logic              pending_r;
    logic              rd_en_s;
    logic              rd_last_s;
    logic              rd_start_s;
    logic              rd_valid_r;
    logic              rd_sof_r;
    logic              rd_eof_r;
    logic [DW2-1:0]    rd_data_s;

    assign wr_rev_s     = bitrev(MAX_AW'(wr_cnt_r), AW);
    assign frame_done_s = din_valid && (wr_cnt_r == AW'(FFT_SIZE - 1));
    assign rd_last_s    = (rd_cnt_r == AW'(FFT_SIZE - 1));

    fft_dp_ram #(
        .ADDR_W (AW + 1),
        .DATA_W (DW2)
    ) u_ram (
        .clk   (clk),
        .we    (din_valid),
        .waddr ({wr_bank_r, wr_rev_s[AW-1:0]}),
        .wdata ({din_re, din_im}),
        .raddr ({rd_bank_r, rd_cnt_r}),
        .rdata (rd_data_s)
    );

    // Write counter and bank toggle on frame wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_r  <= {AW{1'b0}};
            wr_bank_r <= 1'b0;
        end else if (din_valid) begin
            wr_cnt_r  <= wr_cnt_r + AW'(1);
            wr_bank_r <= frame_done_s ? ~wr_bank_r : wr_bank_r;
        end else begin
            wr_cnt_r  <= wr_cnt_r;
            wr_bank_r <= wr_bank_r;
        end
    end

    // Full flags: set on fill completion, cleared on drain completion; set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 2'b00;
        end else begin
            full_r <= (full_r & ~((rd_en_s && rd_last_s) ? (2'b01 << rd_bank_r) : 2'b00))
                    | (frame_done_s ? (2'b01 << wr_bank_r) : 2'b00);
        end
    end

    // Sticky overflow: any write landing in a bank not yet drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (din_valid && full_r[wr_bank_r]) begin
            ovf <= 1'b1;
        end else begin
            ovf <= ovf;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_r <= IDLE;
        end else begin
            rd_state_r <= rd_state_s;
        end
    end

    // Read FSM next-state logic; a pending or same-cycle frame_done keeps READ
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            IDLE: begin
                if (frame_done_s) rd_state_s = READ;
                else              rd_state_s = IDLE;
            end
            READ: begin
                if (rd_last_s && !(pending_r || frame_done_s)) rd_state_s = IDLE;
                else                                           rd_state_s = READ;
            end
            default: rd_state_s = IDLE;
        endcase
    end

    // Read FSM outputs: read enable and frame (re)start strobe
    always_comb begin
        rd_en_s    = 1'b0;
        rd_start_s = 1'b0;
        case (rd_state_r)
            IDLE: begin
                rd_en_s    = 1'b0;
                rd_start_s = frame_done_s;
            end
            READ: begin
                rd_en_s    = 1'b1;
                rd_start_s = rd_last_s && (pending_r || frame_done_s);
            end
            default: begin
                rd_en_s    = 1'b0;
                rd_start_s = 1'b0;
            end
        endcase
    end

    // Read counter, drained-bank select and 1-deep pending frame flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_r  <= {AW{1'b0}};
            rd_bank_r <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            if (rd_start_s) begin
                rd_cnt_r  <= {AW{1'b0}};
                // From IDLE the just-filled bank is still wr_bank_r; back to back it is the other bank
                rd_bank_r <= (rd_state_r == IDLE) ? wr_bank_r : ~rd_bank_r;
            end else if (rd_en_s) begin
                rd_cnt_r  <= rd_cnt_r + AW'(1);
                rd_bank_r <= rd_bank_r;
            end else begin
                rd_cnt_r  <= rd_cnt_r;
                rd_bank_r <= rd_bank_r;
            end
            if (rd_en_s && rd_last_s) begin
                pending_r <= 1'b0;
            end else if (rd_en_s && frame_done_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Markers aligned with the 1-cycle RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_sof_r   <= 1'b0;
            rd_eof_r   <= 1'b0;
        end else begin
            rd_valid_r <= rd_en_s;
            rd_sof_r   <= rd_en_s && (rd_cnt_r == {AW{1'b0}});
            rd_eof_r   <= rd_en_s && rd_last_s;
        end
    end

    // Output registers; data holds when not valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_re    <= {DATA_WIDTH{1'b0}};
            dout_im    <= {DATA_WIDTH{1'b0}};
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
        end else begin
            dout_valid <= rd_valid_r;
            dout_sof   <= rd_sof_r;
            dout_eof   <= rd_eof_r;
            if (rd_valid_r) begin
                dout_re <= rd_data_s[DW2-1:DATA_WIDTH];
                dout_im <= rd_data_s[DATA_WIDTH-1:0];
            end else begin
                dout_re <= dout_re;
                dout_im <= dout_im;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;
    localparam int N  = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din_re = 16'd0;
    logic [DW-1:0] din_im = 16'd0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] dout_re;
    logic [DW-1:0] dout_im;
    logic          dout_valid;
    logic          dout_sof;
    logic          dout_eof;
    logic          ovf;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sof;
        logic          eof;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sof_cyc = -1;
    int   last_edge = 0;
    bit   in_frame = 1'b0;
    // input index that lands in output bin n (hand-computed 3-bit reversal)
    int   brtab[N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_bitrev_reorder #(.FFT_SIZE(N), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_re     (din_re),
        .din_im     (din_im),
        .din_valid  (din_valid),
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .dout_eof   (dout_eof),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    task automatic push_frame(input int base);
        exp_t e;
        for (int n = 0; n < N; n++) begin
            e.re  = 16'(base + brtab[n]);
            e.im  = 16'(base + brtab[n]) ^ 16'h5A5A;
            e.sof = (n == 0);
            e.eof = (n == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_sample(input int v);
        @(posedge clk); #1;
        din_valid = 1'b1;
        din_re    = 16'(v);
        din_im    = 16'(v) ^ 16'h5A5A;
        last_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            din_valid = 1'b0;
        end
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: pop expected entry whenever the DUT presents a sample
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (in_frame) begin
                checks++;
                if (!dout_valid) begin
                    errors++;
                    $display("FAIL gap valid=%0b required=1", dout_valid);
                end
            end
            if (dout_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out re=%0h", dout_re);
                end else begin
                    e = exp_q.pop_front();
                    if (dout_re !== e.re || dout_im !== e.im || dout_sof !== e.sof || dout_eof !== e.eof) begin
                        errors++;
                        $display("FAIL out_bin got re=%0h im=%0h sof=%0b eof=%0b required re=%0h im=%0h sof=%0b eof=%0b",
                                 dout_re, dout_im, dout_sof, dout_eof, e.re, e.im, e.sof, e.eof);
                    end
                end
                if (dout_sof) sof_cyc = cyc;
                in_frame = !dout_eof;
            end else begin
                in_frame = 1'b0;
            end
        end else begin
            in_frame = 1'b0;
        end
    end

    initial begin
        // reset values
        repeat (2) @(posedge clk); #1;
        chk("rst_valid", dout_valid, 0);
        chk("rst_flags", {dout_sof, dout_eof, ovf}, 0);
        chk("rst_data", {dout_re, dout_im}, 0);
        @(negedge clk); rst_n = 1'b1;

        // single frame, latency of bin 0 after last input
        push_frame(0);
        for (int k = 0; k < N; k++) drive_sample(k);
        idle(1);
        wait_empty("drain_single");
        chk("latency", sof_cyc - last_edge, 2);

        // three frames back to back at full rate
        push_frame(16); push_frame(32); push_frame(48);
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < N; k++) drive_sample(16 * (f + 1) + k);
        idle(1);
        wait_empty("drain_b2b");
        chk("ovf_b2b", ovf, 0);

        // valid toggling every other cycle
        push_frame(64); push_frame(80);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < N; k++) begin
                drive_sample(64 + 16 * f + k);
                idle(1);
            end
        wait_empty("drain_gaps");

        // reset at output bin 3 with a partial input frame in flight
        push_frame(96);
        for (int k = 0; k < N; k++) drive_sample(96 + k);
        for (int k = 0; k < 3; k++) drive_sample(112 + k);
        idle(1);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (dout_valid && dout_re == 16'd102) found = 1'b1;
            end
            chk("bin3_seen", found, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {dout_valid, dout_sof, dout_eof}, 0);
        chk("midrst_data", {dout_re, dout_im}, 0);
        exp_q.delete();
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        push_frame(128);
        for (int k = 0; k < N; k++) drive_sample(128 + k);
        idle(1);
        wait_empty("drain_after_rst");

        // overflow hook: write into a bank flagged full
        force dut.full_r = 2'b11;
        push_frame(144);
        drive_sample(144);
        idle(1);
        release dut.full_r;
        chk("ovf_set", ovf, 1);
        for (int k = 1; k < N; k++) drive_sample(144 + k);
        idle(1);
        wait_empty("drain_ovf");
        chk("ovf_sticky", ovf, 1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("ovf_cleared", ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
